shift_register_serializer_ctrl: RTL

- Sequencer that turns the parameterized shift register into a framed parallel-to-serial transmitter.
- Accepts a parallel word on an upstream valid/ready handshake and drives the register's load, enable, sclr, shiftin and data pins.
- Steps the register one bit per cycle and presents sr_shiftout downstream as a valid/ready serial stream with a last flag.
- Sits between a word producer and a bit-serial link; the shift register is instantiated beside it and is not inside this block.

---
 rtl/shift_register_serializer_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shift_register_serializer_ctrl.sv
// rtl/shift_register_serializer_ctrl.sv - sequences an external shift register into a framed serial transmitter
module shift_register_serializer_ctrl #(
  parameter int   SHIFT_WIDTH = 8,
  parameter int   GAP_CYCLES  = 2,
  parameter logic FILL_BIT    = 1'b0
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] in_data,
  input  logic                   abort,
  input  logic                   ser_ready,
  output logic                   ser_valid,
  output logic                   ser_bit,
  output logic                   ser_last,
  output logic                   busy,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic                   sr_sclr,
  output logic                   sr_shiftin,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  input  logic                   sr_shiftout
);

  localparam int CW = $clog2(SHIFT_WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic          capture;

  assign ser_bit    = sr_shiftout;
  assign sr_shiftin = FILL_BIT;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sr_data <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      gap_cnt <= gap_cnt_next;
      if (capture) begin
        sr_data <= in_data;
      end
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    gap_cnt_next = gap_cnt;
    capture      = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b1;
    ser_valid    = 1'b0;
    ser_last     = 1'b0;
    sr_load      = 1'b0;
    sr_enable    = 1'b0;
    sr_sclr      = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_next = '0;
        sr_enable    = 1'b1;
        if (abort) begin
          sr_sclr    = 1'b1;
          state_next = IDLE;
        end else begin
          sr_load    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Abort takes priority over a simultaneous transfer; the bit is dropped.
        if (abort) begin
          sr_sclr      = 1'b1;
          sr_enable    = 1'b1;
          bit_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          ser_valid = 1'b1;
          ser_last  = (bit_cnt == LAST_CNT);
          sr_enable = ser_ready;
          if (ser_ready) begin
            if (bit_cnt == LAST_CNT) begin
              bit_cnt_next = '0;
              gap_cnt_next = '0;
              state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              bit_cnt_next = bit_cnt + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          sr_sclr   = 1'b1;
          sr_enable = 1'b1;
        end
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
